// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight register writers after decode,
// selects forwarding sources, detects load-use stalls and counts them.
module pipe_hazard_ctrl #(
    parameter int NSTAGE     = 3,
    parameter int AW         = 5,
    parameter int LOAD_READY = 2,
    parameter int FW         = $clog2(NSTAGE + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wreg,
    input  logic          id_m2reg,
    input  logic [AW-1:0] id_rn,
    input  logic          stall_ext,
    input  logic          flush,
    output logic          wpcir,
    output logic          bubble,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rn,
    output logic [15:0]   hz_count
);

    typedef struct packed {
        logic          valid;
        logic          wreg;
        logic          m2reg;
        logic [AW-1:0] rn;
    } entry_t;

    entry_t        tbl [1:NSTAGE];
    entry_t        new_entry;
    logic [FW-1:0] sel_a;
    logic [FW-1:0] sel_b;
    logic          late_a;
    logic          late_b;
    logic          load_use;

    // Scan oldest to youngest so the youngest matching producer wins; a load
    // that has not yet reached LOAD_READY cannot supply its value.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        late_a = 1'b0;
        late_b = 1'b0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (tbl[k].valid && tbl[k].wreg && id_use_rs &&
                (id_rs != '0) && (tbl[k].rn == id_rs)) begin
                sel_a  = FW'(k);
                late_a = tbl[k].m2reg && (k < LOAD_READY);
            end
            if (tbl[k].valid && tbl[k].wreg && id_use_rt &&
                (id_rt != '0) && (tbl[k].rn == id_rt)) begin
                sel_b  = FW'(k);
                late_b = tbl[k].m2reg && (k < LOAD_READY);
            end
        end
    end

    // A flushed decode slot never stalls, even if it would have needed a load.
    always_comb begin
        load_use = id_valid && !flush && (late_a || late_b);
        wpcir    = !(load_use || stall_ext);
        bubble   = load_use && !stall_ext;
        fwd_a    = load_use ? '0 : sel_a;
        fwd_b    = load_use ? '0 : sel_b;
        wb_valid = tbl[NSTAGE].valid && tbl[NSTAGE].wreg;
        wb_rn    = tbl[NSTAGE].rn;
    end

    always_comb begin
        new_entry = '0;
        if (id_valid && !load_use && !flush) begin
            new_entry = {1'b1, id_wreg, id_m2reg, id_rn};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                tbl[k] <= '0;
            end
        end else if (!stall_ext) begin
            for (int k = NSTAGE; k >= 2; k--) begin
                tbl[k] <= tbl[k-1];
            end
            tbl[1] <= new_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hz_count <= '0;
        end else if (!stall_ext && load_use && (hz_count != 16'hFFFF)) begin
            hz_count <= hz_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: forwarding, load-use
// stalls, external freeze, flush priority and reset with work in flight.
module tb_pipe_hazard_ctrl;

    logic       clock;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wreg;
    logic       id_m2reg;
    logic [4:0] id_rn;
    logic       stall_ext;
    logic       flush;
    logic       wpcir;
    logic       bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       wb_valid;
    logic [4:0] wb_rn;
    logic [15:0] hz_count;

    int vectors;
    int miscompares;
    int exp_hz;

    pipe_hazard_ctrl dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_rn(id_rn),
        .stall_ext(stall_ext), .flush(flush), .wpcir(wpcir), .bubble(bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_valid(wb_valid), .wb_rn(wb_rn),
        .hz_count(hz_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic w,
                          input logic m, input logic [4:0] rn);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_wreg   = w;
        id_m2reg  = m;
        id_rn     = rn;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        stall_ext = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++; if (wpcir !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_wpcir got %0d want 1", wpcir); end
        vectors++; if (bubble !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bubble got %0d want 0", bubble); end
        vectors++; if ({fwd_a, fwd_b} !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_fwd got a=%0d b=%0d want 0/0", fwd_a, fwd_b); end
        vectors++; if ({wb_valid, wb_rn} !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_wb got v=%0d rn=%0d want 0/0", wb_valid, wb_rn); end
        vectors++; if (hz_count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_hz got %0d want 0", hz_count); end
        exp_hz = 0;
    endtask

    task automatic test_alu_forward();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        step();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        vectors++; if (fwd_a !== 2'd1) begin miscompares++; $display("[TB] FAIL alu_fwd_s1 got %0d want 1", fwd_a); end
        vectors++; if (wpcir !== 1'b1) begin miscompares++; $display("[TB] FAIL alu_wpcir got %0d want 1", wpcir); end
        step();
        #1;
        vectors++; if (fwd_a !== 2'd2) begin miscompares++; $display("[TB] FAIL alu_fwd_s2 got %0d want 2", fwd_a); end
        step();
        #1;
        vectors++; if (fwd_a !== 2'd3) begin miscompares++; $display("[TB] FAIL alu_fwd_s3 got %0d want 3", fwd_a); end
        vectors++; if ({wb_valid, wb_rn} !== {1'b1, 5'd3}) begin miscompares++; $display("[TB] FAIL alu_wb got v=%0d rn=%0d want 1/3", wb_valid, wb_rn); end
        step();
        #1;
        vectors++; if (fwd_a !== 2'd0) begin miscompares++; $display("[TB] FAIL alu_fwd_gone got %0d want 0", fwd_a); end
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL alu_wb_reader got %0d want 0", wb_valid); end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
        step();
        set_id(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6);
        #1;
        vectors++; if ({wpcir, bubble} !== 2'b01) begin miscompares++; $display("[TB] FAIL lu_stall got wpcir=%0d bubble=%0d want 0/1", wpcir, bubble); end
        vectors++; if (fwd_b !== 2'd0) begin miscompares++; $display("[TB] FAIL lu_fwd_zero got %0d want 0", fwd_b); end
        vectors++; if (hz_count !== 16'd0) begin miscompares++; $display("[TB] FAIL lu_hz_before got %0d want 0", hz_count); end
        step();
        exp_hz++;
        #1;
        vectors++; if (hz_count !== 16'd1) begin miscompares++; $display("[TB] FAIL lu_hz_after got %0d want 1", hz_count); end
        vectors++; if ({wpcir, bubble} !== 2'b10) begin miscompares++; $display("[TB] FAIL lu_release got wpcir=%0d bubble=%0d want 1/0", wpcir, bubble); end
        vectors++; if (fwd_b !== 2'd2) begin miscompares++; $display("[TB] FAIL lu_fwd_s2 got %0d want 2", fwd_b); end
        step();
        #1;
        vectors++; if ({wb_valid, wb_rn} !== {1'b1, 5'd5}) begin miscompares++; $display("[TB] FAIL lu_wb got v=%0d rn=%0d want 1/5", wb_valid, wb_rn); end
        vectors++; if (hz_count !== 16'd1) begin miscompares++; $display("[TB] FAIL lu_hz_hold got %0d want 1", hz_count); end
        drain();
    endtask

    task automatic test_multi_match();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
        step();
        step();
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        vectors++; if ({fwd_a, fwd_b} !== {2'd1, 2'd1}) begin miscompares++; $display("[TB] FAIL multi_youngest got a=%0d b=%0d want 1/1", fwd_a, fwd_b); end
        id_use_rs = 1'b0;
        #1;
        vectors++; if ({fwd_a, fwd_b} !== {2'd0, 2'd1}) begin miscompares++; $display("[TB] FAIL multi_use_gate got a=%0d b=%0d want 0/1", fwd_a, fwd_b); end
        drain();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        vectors++; if ({fwd_a, fwd_b} !== 4'd0) begin miscompares++; $display("[TB] FAIL r0_nofwd got a=%0d b=%0d want 0/0", fwd_a, fwd_b); end
        vectors++; if (wpcir !== 1'b1) begin miscompares++; $display("[TB] FAIL r0_nostall got %0d want 1", wpcir); end
        drain();
    endtask

    task automatic test_stall_ext();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
        step();
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({fwd_a, fwd_b} !== {2'd2, 2'd1}) begin miscompares++; $display("[TB] FAIL frz_fwd[%0d] got a=%0d b=%0d want 2/1", i, fwd_a, fwd_b); end
            vectors++; if ({wpcir, bubble} !== 2'b00) begin miscompares++; $display("[TB] FAIL frz_ctrl[%0d] got wpcir=%0d bubble=%0d want 0/0", i, wpcir, bubble); end
            vectors++; if ({wb_valid, wb_rn} !== {1'b1, 5'd1}) begin miscompares++; $display("[TB] FAIL frz_wb[%0d] got v=%0d rn=%0d want 1/1", i, wb_valid, wb_rn); end
            step();
        end
        #1;
        vectors++; if ({fwd_a, fwd_b, wb_rn} !== {2'd2, 2'd1, 5'd1}) begin miscompares++; $display("[TB] FAIL frz_after got a=%0d b=%0d rn=%0d want 2/1/1", fwd_a, fwd_b, wb_rn); end
        vectors++; if (hz_count !== exp_hz[15:0]) begin miscompares++; $display("[TB] FAIL frz_hz got %0d want %0d", hz_count, exp_hz); end
        stall_ext = 1'b0;
        step();
        #1;
        vectors++; if ({fwd_a, fwd_b, wb_rn} !== {2'd3, 2'd2, 5'd2}) begin miscompares++; $display("[TB] FAIL frz_resume got a=%0d b=%0d rn=%0d want 3/2/2", fwd_a, fwd_b, wb_rn); end
        drain();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8);
        step();
        set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        stall_ext = 1'b1;
        #1;
        vectors++; if ({wpcir, bubble, fwd_a} !== {1'b0, 1'b0, 2'd0}) begin miscompares++; $display("[TB] FAIL frz_lu got wpcir=%0d bubble=%0d a=%0d want 0/0/0", wpcir, bubble, fwd_a); end
        step();
        #1;
        vectors++; if (hz_count !== exp_hz[15:0]) begin miscompares++; $display("[TB] FAIL frz_lu_hz got %0d want %0d", hz_count, exp_hz); end
        stall_ext = 1'b0;
        #1;
        vectors++; if ({wpcir, bubble} !== 2'b01) begin miscompares++; $display("[TB] FAIL lu_unfrz got wpcir=%0d bubble=%0d want 0/1", wpcir, bubble); end
        step();
        exp_hz++;
        #1;
        vectors++; if (hz_count !== exp_hz[15:0]) begin miscompares++; $display("[TB] FAIL lu_unfrz_hz got %0d want %0d", hz_count, exp_hz); end
        vectors++; if ({wpcir, fwd_a} !== {1'b1, 2'd2}) begin miscompares++; $display("[TB] FAIL lu_unfrz_fwd got wpcir=%0d a=%0d want 1/2", wpcir, fwd_a); end
        drain();
    endtask

    task automatic test_flush();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
        step();
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
        flush = 1'b1;
        #1;
        vectors++; if ({wpcir, bubble} !== 2'b10) begin miscompares++; $display("[TB] FAIL flush_ctrl got wpcir=%0d bubble=%0d want 1/0", wpcir, bubble); end
        vectors++; if (fwd_a !== 2'd1) begin miscompares++; $display("[TB] FAIL flush_fwd got %0d want 1", fwd_a); end
        step();
        flush = 1'b0;
        set_id(1'b1, 5'd9, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        vectors++; if ({fwd_a, fwd_b} !== {2'd0, 2'd2}) begin miscompares++; $display("[TB] FAIL flush_bubble got a=%0d b=%0d want 0/2", fwd_a, fwd_b); end
        vectors++; if (hz_count !== exp_hz[15:0]) begin miscompares++; $display("[TB] FAIL flush_hz got %0d want %0d", hz_count, exp_hz); end
        drain();
    endtask

    task automatic test_reset_inflight();
        repeat (4 - exp_hz) begin
            set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10);
            step();
            set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
            step();
            step();
            exp_hz++;
        end
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd13);
        step();
        set_id(1'b1, 5'd0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        stall_ext = 1'b1;
        #1;
        vectors++; if (hz_count !== 16'd4) begin miscompares++; $display("[TB] FAIL rst_pre_hz got %0d want 4", hz_count); end
        vectors++; if ({wb_valid, wb_rn, wpcir} !== {1'b1, 5'd11, 1'b0}) begin miscompares++; $display("[TB] FAIL rst_pre got v=%0d rn=%0d wpcir=%0d want 1/11/0", wb_valid, wb_rn, wpcir); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        exp_hz = 0;
        #1;
        vectors++; if ({wpcir, bubble, fwd_a, fwd_b} !== 6'b100000) begin miscompares++; $display("[TB] FAIL rst_ctrl got wpcir=%0d bubble=%0d a=%0d b=%0d want 1/0/0/0", wpcir, bubble, fwd_a, fwd_b); end
        vectors++; if ({wb_valid, wb_rn} !== 6'd0) begin miscompares++; $display("[TB] FAIL rst_wb got v=%0d rn=%0d want 0/0", wb_valid, wb_rn); end
        vectors++; if (hz_count !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_hz got %0d want 0", hz_count); end
        set_id(1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        vectors++; if ({wpcir, fwd_a, fwd_b} !== 5'b10000) begin miscompares++; $display("[TB] FAIL rst_table got wpcir=%0d a=%0d b=%0d want 1/0/0", wpcir, fwd_a, fwd_b); end
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd14);
        step();
        set_id(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        vectors++; if (fwd_a !== 2'd1) begin miscompares++; $display("[TB] FAIL rst_first_accept got %0d want 1", fwd_a); end
        drain();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_hz      = 0;
        reset       = 1'b1;
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_multi_match();
        test_stall_ext();
        test_flush();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
